pcileech_board_sysctl: RTL and testbench
========================================

// Module: pcileech_board_sysctl
// PURPOSE
//  Parametrised board system controller: power-on reset sequencer, 64-bit tick counter and multi-channel LED driver.
//  Instantiated once per board top. Replaces the per-top tickcount/reset logic and the raw LED wiring.
//  Releases N downstream resets in a staggered order (COM, FIFO, PCIe, ...).
//  Drives LEDs in off/on/blink/activity-stretch modes, with a lamp test during reset hold.
// PARAMETERS
//  RST_HOLD_CYCLES     64        ticks before rst_out[0] deasserts (>=1)
//  NUM_RST_OUT         3         number of staggered reset outputs (>=1)
//  RST_STAGGER         16        ticks between consecutive rst_out deasserts (>=0)
//  NUM_LED             2         LED channels (>=1)
//  BLINK_LOG2          24        blink half-period = 2^BLINK_LOG2 ticks (1..62)
//  STRETCH_CYCLES      4000000   activity pulse-stretch length in cycles (>=1)
// PORTS
//  clk          in   1              system clock; the only clock
//  rst_n        in   1              synchronous, active-low reset (sampled on posedge clk)
//  tickcount64  out  64             cycles since rst_n release
//  rst_out      out  NUM_RST_OUT    active-high downstream resets
//  rst_done     out  1              all rst_out deasserted
//  led_mode     in   2*NUM_LED      per-channel mode [2i+1:2i]: 00 off, 01 on, 10 blink, 11 activity
//  led_act      in   NUM_LED        activity strobes (level or pulse, sampled each cycle)
//  led_invert   in   NUM_LED        per-channel output polarity invert
//  led_out      out  NUM_LED        LED pad drive (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge). Takes effect the same edge. Applies mid-operation in any state.
//   tickcount64=0, rst_out=all 1, rst_done=0, led_out=0.
//   All stretch counters=0, FSM=S_HOLD.
//  tickcount64 increments by 1 on every edge with rst_n=1. Wraps modulo 2^64; no saturation.
//  Let T = tickcount64 value after the edge. Define LAST = RST_HOLD_CYCLES + (NUM_RST_OUT-1)*RST_STAGGER.
//  rst_out[i] is registered and computed from T: rst_out[i] <= (T < RST_HOLD_CYCLES + i*RST_STAGGER).
//   It falls on the edge where T reaches its threshold.
//  FSM (encodes the release sequence):
//   S_HOLD: entered on reset. Moves to S_STAGGER on the edge where T = RST_HOLD_CYCLES.
//   S_STAGGER: moves to S_RUN on the edge where T = LAST. If LAST = RST_HOLD_CYCLES, S_HOLD goes directly to S_RUN.
//   S_RUN: terminal. rst_done=1 here, set on the same edge rst_out[NUM_RST_OUT-1] falls.
//   Wrap of tickcount64 does NOT re-assert rst_out; only rst_n does.
//  LED logic: each channel computes raw[i] and registers led_out[i] <= raw[i] ^ led_invert[i].
//   led_out lags its inputs by 1 cycle.
//   S_HOLD: raw=1 for all channels (lamp test), regardless of led_mode.
//   S_STAGGER/S_RUN: raw is selected by mode.
//    off: raw=0.
//    on: raw=1.
//    blink: raw = tickcount64[BLINK_LOG2].
//    activity: raw = (stretch[i] != 0).
//  Stretch counter: width $clog2(STRETCH_CYCLES+1). Runs in every state and every mode.
//   If led_act[i]=1 it loads STRETCH_CYCLES; otherwise it decrements when nonzero.
//   Load wins over decrement (retrigger extends the pulse). It holds at 0.
//  Mode or invert change: takes effect on the next edge. The stretch counter is not cleared.
// TESTING
//  Defaults, rst_n low 5 cycles then high -> rst_out=111 until T=64.
//   rst_out[0] falls at T=64, [1] at T=80, [2] at T=96.
//   rst_done rises at T=96. tickcount64 = cycle count.
//  Lamp test: led_mode=00, led_invert=2'b10 -> led_out=2'b01 during S_HOLD. Becomes 2'b10 one cycle after S_HOLD exits.
//  Blink: BLINK_LOG2=3, mode=10 -> led_out toggles every 8 cycles.
//   led_out follows tickcount64[3] with 1-cycle lag.
//  Activity: STRETCH_CYCLES=10, 1-cycle led_act pulse -> led_out high for exactly 10 cycles.
//   A second pulse at count 3 extends it to 10 cycles from the second pulse.
//  Reset mid-sequence: drop rst_n at T=70 -> next edge: rst_out=111, tickcount64=0, led_out=0, FSM=S_HOLD.
//   After re-release the full sequence repeats.
//  Edge params: NUM_RST_OUT=1, RST_STAGGER=0, RST_HOLD_CYCLES=1 -> rst_out and rst_done change on the first edge after release (T=1).

Source files
------------

// File: rtl/pcileech_board_sysctl.sv
// pcileech_board_sysctl: staggered power-on reset sequencer, 64-bit tick counter and LED driver
module pcileech_board_sysctl #(
    parameter int RST_HOLD_CYCLES = 64,
    parameter int NUM_RST_OUT     = 3,
    parameter int RST_STAGGER     = 16,
    parameter int NUM_LED         = 2,
    parameter int BLINK_LOG2      = 24,
    parameter int STRETCH_CYCLES  = 4000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [63:0]            tickcount64,
    output logic [NUM_RST_OUT-1:0] rst_out,
    output logic                   rst_done,
    input  logic [2*NUM_LED-1:0]   led_mode,
    input  logic [NUM_LED-1:0]     led_act,
    input  logic [NUM_LED-1:0]     led_invert,
    output logic [NUM_LED-1:0]     led_out
);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [63:0] HOLD = 64'(RST_HOLD_CYCLES);
    localparam logic [63:0] LAST = HOLD + 64'(NUM_RST_OUT - 1) * 64'(RST_STAGGER);
    localparam logic [SW-1:0] STRETCH = SW'(STRETCH_CYCLES);

    typedef enum logic [1:0] {S_HOLD, S_STAGGER, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [63:0]            tick_q, tick_d;
    logic [NUM_RST_OUT-1:0] rst_q, rst_d;
    logic [NUM_LED-1:0]     led_q, led_d;
    logic [SW-1:0]          str_q [NUM_LED];
    logic [SW-1:0]          str_d [NUM_LED];

    always_comb begin
        tick_d  = tick_q + 64'd1;
        state_d = (state_q == S_HOLD && tick_d == HOLD) ? ((LAST == HOLD) ? S_RUN : S_STAGGER) :
                  (state_q == S_STAGGER && tick_d == LAST) ? S_RUN : state_q;
        // AND with the old value keeps released resets released across a tick wrap
        for (int i = 0; i < NUM_RST_OUT; i++)
            rst_d[i] = rst_q[i] && (tick_d < HOLD + 64'(i) * 64'(RST_STAGGER));
        for (int i = 0; i < NUM_LED; i++) begin
            str_d[i] = led_act[i] ? STRETCH : (str_q[i] != '0) ? str_q[i] - SW'(1) : str_q[i];
            led_d[i] = led_invert[i] ^ (state_q == S_HOLD ||
                       (led_mode[2*i+1] ? (led_mode[2*i] ? (str_q[i] != '0) : tick_q[BLINK_LOG2])
                                        : led_mode[2*i]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q  <= '0;
            state_q <= S_HOLD;
            rst_q   <= '1;
            led_q   <= '0;
            for (int i = 0; i < NUM_LED; i++) str_q[i] <= '0;
        end else begin
            tick_q  <= tick_d;
            state_q <= state_d;
            rst_q   <= rst_d;
            led_q   <= led_d;
            for (int i = 0; i < NUM_LED; i++) str_q[i] <= str_d[i];
        end
    end

    assign tickcount64 = tick_q;
    assign rst_out     = rst_q;
    assign rst_done    = state_q == S_RUN;
    assign led_out     = led_q;
endmodule

// File: tb/tb_pcileech_board_sysctl.sv
// tb_pcileech_board_sysctl: directed checks of reset sequencing, lamp test, blink and activity stretch
module tb_pcileech_board_sysctl;
    logic        clk = 1'b0;
    logic        rst_n, rst_n_b;
    logic [63:0] tick_a, tick_b;
    logic [2:0]  rst_a;
    logic [0:0]  rst_b;
    logic        done_a, done_b;
    logic [3:0]  mode_a, mode_b;
    logic [1:0]  act_a, act_b, inv_a, inv_b, led_a, led_b;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] t, prev;

    always #5 clk = ~clk;

    pcileech_board_sysctl #(.BLINK_LOG2(3), .STRETCH_CYCLES(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .tickcount64(tick_a), .rst_out(rst_a), .rst_done(done_a),
        .led_mode(mode_a), .led_act(act_a), .led_invert(inv_a), .led_out(led_a));

    pcileech_board_sysctl #(.RST_HOLD_CYCLES(1), .NUM_RST_OUT(1), .RST_STAGGER(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .tickcount64(tick_b), .rst_out(rst_b), .rst_done(done_b),
        .led_mode(mode_b), .led_act(act_b), .led_invert(inv_b), .led_out(led_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_edge_params();
        rst_n_b = 1'b0;
        repeat (3) step();
        n_cmp += 4;
        if (tick_b !== 64'd0) begin n_bad++; $display("FAIL edge_reset_tick got %0d want 0", tick_b); end
        if (rst_b !== 1'b1) begin n_bad++; $display("FAIL edge_reset_rst got %b want 1", rst_b); end
        if (done_b !== 1'b0) begin n_bad++; $display("FAIL edge_reset_done got %b want 0", done_b); end
        if (led_b !== 2'b00) begin n_bad++; $display("FAIL edge_reset_led got %b want 00", led_b); end
        rst_n_b = 1'b1;
        step();
        n_cmp += 4;
        if (tick_b !== 64'd1) begin n_bad++; $display("FAIL edge_t1_tick got %0d want 1", tick_b); end
        if (rst_b !== 1'b0) begin n_bad++; $display("FAIL edge_t1_rst got %b want 0", rst_b); end
        if (done_b !== 1'b1) begin n_bad++; $display("FAIL edge_t1_done got %b want 1", done_b); end
        if (led_b !== 2'b11) begin n_bad++; $display("FAIL edge_t1_lamp got %b want 11", led_b); end
        step();
        n_cmp += 2;
        if (tick_b !== 64'd2) begin n_bad++; $display("FAIL edge_t2_tick got %0d want 2", tick_b); end
        if (led_b !== 2'b00) begin n_bad++; $display("FAIL edge_t2_led got %b want 00", led_b); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) step();
        n_cmp += 4;
        if (tick_a !== 64'd0) begin n_bad++; $display("FAIL reset_tick got %0d want 0", tick_a); end
        if (rst_a !== 3'b111) begin n_bad++; $display("FAIL reset_rst got %b want 111", rst_a); end
        if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done_a); end
        if (led_a !== 2'b00) begin n_bad++; $display("FAIL reset_led got %b want 00", led_a); end
    endtask

    task automatic test_sequence();
        logic [2:0] exp_rst;
        logic [1:0] exp_led;
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            exp_rst = {k < 96, k < 80, k < 64};
            exp_led = (k <= 64) ? 2'b01 : 2'b10;
            n_cmp += 4;
            if (tick_a !== 64'(k)) begin n_bad++; $display("FAIL seq_tick k=%0d got %0d want %0d", k, tick_a, k); end
            if (rst_a !== exp_rst) begin n_bad++; $display("FAIL seq_rst k=%0d got %b want %b", k, rst_a, exp_rst); end
            if (done_a !== (k >= 96)) begin n_bad++; $display("FAIL seq_done k=%0d got %b want %b", k, done_a, k >= 96); end
            if (led_a !== exp_led) begin n_bad++; $display("FAIL seq_lamp k=%0d got %b want %b", k, led_a, exp_led); end
        end
        t = 64'd100;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (70) step();
        n_cmp += 1;
        if (rst_a !== 3'b110) begin n_bad++; $display("FAIL mid_pre_rst got %b want 110", rst_a); end
        rst_n = 1'b0;
        step();
        n_cmp += 4;
        if (tick_a !== 64'd0) begin n_bad++; $display("FAIL mid_tick got %0d want 0", tick_a); end
        if (rst_a !== 3'b111) begin n_bad++; $display("FAIL mid_rst got %b want 111", rst_a); end
        if (done_a !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b want 0", done_a); end
        if (led_a !== 2'b00) begin n_bad++; $display("FAIL mid_led got %b want 00", led_a); end
        test_sequence();
    endtask

    task automatic test_blink();
        logic [1:0] exp_led;
        mode_a = 4'b0110;
        inv_a  = 2'b00;
        for (int k = 0; k < 40; k++) begin
            prev = t;
            t = t + 64'd1;
            step();
            exp_led = {1'b1, prev[3]};
            n_cmp += 2;
            if (tick_a !== t) begin n_bad++; $display("FAIL blink_tick got %0d want %0d", tick_a, t); end
            if (led_a !== exp_led) begin n_bad++; $display("FAIL blink_led t=%0d got %b want %b", t, led_a, exp_led); end
        end
    endtask

    task automatic test_activity();
        logic [1:0] exp_led;
        mode_a = 4'b1111;
        inv_a  = 2'b10;
        act_a  = 2'b01;
        step();
        act_a = 2'b00;
        n_cmp += 1;
        if (led_a !== 2'b10) begin n_bad++; $display("FAIL act_pulse_edge got %b want 10", led_a); end
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_led = {1'b1, k <= 10};
            n_cmp += 1;
            if (led_a !== exp_led) begin n_bad++; $display("FAIL act_single k=%0d got %b want %b", k, led_a, exp_led); end
        end
        act_a = 2'b01;
        step();
        for (int k = 1; k <= 20; k++) begin
            act_a = {1'b0, k == 7};
            step();
            exp_led = {1'b1, k <= 17};
            n_cmp += 1;
            if (led_a !== exp_led) begin n_bad++; $display("FAIL act_retrigger k=%0d got %b want %b", k, led_a, exp_led); end
        end
        act_a = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0;
        mode_a = 4'b0000; act_a = 2'b00; inv_a = 2'b10;
        mode_b = 4'b0000; act_b = 2'b00; inv_b = 2'b00;
        t = '0; prev = '0;
        test_edge_params();
        test_reset();
        test_sequence();
        test_reset_mid();
        test_blink();
        test_activity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
